if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 90 +++++++++
 tb/tb_if_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and tracks
// whether the ROM output currently holds a live instruction for decode.
//
// state | meaning
// IDLE  | out of reset, waiting for enable_CPU
// RUN   | fetching; PC advances on each issued ROM read
// PAUSE | CPU disabled; PC frozen except for branch redirect
// HALT  | halt retired; only rst leaves this state
module if_fetch #(
  parameter int unsigned ADR_BIT  = 16,
  parameter logic [ADR_BIT-1:0] RESET_PC = '0,
  parameter int unsigned CNT_BIT  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_CPU,
  input  logic               ena_n,
  input  logic               branch_taken,
  input  logic [ADR_BIT-1:0] branch_addr,
  input  logic               halt_req,
  output logic [ADR_BIT-1:0] rom_addr,
  output logic               rom_en,
  output logic [ADR_BIT-1:0] pc_next_inw,
  output logic               fetch_valid,
  output logic               halted,
  output logic [CNT_BIT-1:0] fetch_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [ADR_BIT-1:0] pc;
  logic [ADR_BIT-1:0] pc_nxt;

  assign rom_addr    = pc;
  assign pc_next_inw = pc + 1'b1;
  assign rom_en      = (state == ST_RUN) & ~ena_n & ~halt_req;
  assign halted      = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable_CPU) state_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_req)         state_nxt = ST_HALT;
        else if (!enable_CPU) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (halt_req)        state_nxt = ST_HALT;
        else if (enable_CPU) state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_HALT;
    endcase
  end

  // Branches override stalls, and a pending halt overrides branches.
  always_comb begin
    pc_nxt = pc;
    case (state)
      ST_RUN: begin
        if (halt_req)          pc_nxt = pc;
        else if (branch_taken) pc_nxt = branch_addr;
        else if (rom_en)       pc_nxt = pc_next_inw;
      end
      ST_PAUSE: if (branch_taken && !halt_req) pc_nxt = branch_addr;
      default:  pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // The word read alongside a redirect is on the wrong path; kill it.
      if (branch_taken || state_nxt == ST_HALT) fetch_valid <= 1'b0;
      else if (rom_en)                          fetch_valid <= 1'b1;
      if (rom_en) fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table of stimulus with pre-edge and post-edge
// expectations; post-edge expectations travel through a scoreboard queue.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_CPU;
  logic        ena_n;
  logic        branch_taken;
  logic [15:0] branch_addr;
  logic        halt_req;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [15:0] pc_next_inw;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] fetch_count;

  if_fetch #(.ADR_BIT(16), .RESET_PC(16'h0000), .CNT_BIT(32)) dut (
    .clk(clk), .rst(rst), .enable_CPU(enable_CPU), .ena_n(ena_n),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .halt_req(halt_req),
    .rom_addr(rom_addr), .rom_en(rom_en), .pc_next_inw(pc_next_inw),
    .fetch_valid(fetch_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, ena_n, br;
    logic [15:0] baddr;
    logic        halt;
    logic        x_en;
    logic [15:0] x_pcn;
    logic [15:0] x_addr;
    logic        x_fv;
    logic [31:0] x_cnt;
    logic        x_halted;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic        fv;
    logic [31:0] cnt;
    logic        hlt;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic en_n, input logic b,
                     input logic [15:0] ba, input logic h, input logic x_en,
                     input logic [15:0] x_pcn, input logic [15:0] x_addr,
                     input logic x_fv, input logic [31:0] x_cnt, input logic x_h);
    vec_t v;
    v.rst = r; v.en = e; v.ena_n = en_n; v.br = b; v.baddr = ba; v.halt = h;
    v.x_en = x_en; v.x_pcn = x_pcn; v.x_addr = x_addr; v.x_fv = x_fv;
    v.x_cnt = x_cnt; v.x_halted = x_h;
    vecs.push_back(v);
  endtask

  initial begin
    post_t p;
    // rst en ena_n br baddr halt | pre: rom_en pc_next | post: addr fv cnt halted
    add(0,1,0,0,16'h0000,0, 0,16'h0001, 16'h0000,0, 0,0); // IDLE -> RUN
    add(0,1,0,0,16'h0000,0, 1,16'h0001, 16'h0001,1, 1,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0002, 16'h0002,1, 2,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0003, 16'h0003,1, 3,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0004, 16'h0004,1, 4,0);
    add(0,1,0,1,16'h000F,0, 1,16'h0005, 16'h000F,0, 5,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0010, 16'h0010,1, 6,0);
    add(0,1,1,0,16'h0000,0, 0,16'h0011, 16'h0010,1, 6,0); // stall x3
    add(0,1,1,0,16'h0000,0, 0,16'h0011, 16'h0010,1, 6,0);
    add(0,1,1,0,16'h0000,0, 0,16'h0011, 16'h0010,1, 6,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0011, 16'h0011,1, 7,0);
    add(0,1,0,1,16'h0020,0, 1,16'h0012, 16'h0020,0, 8,0);
    add(0,1,0,1,16'h0100,0, 1,16'h0021, 16'h0100,0, 9,0); // branch, no stall
    add(0,1,0,0,16'h0000,0, 1,16'h0101, 16'h0101,1,10,0);
    add(0,1,0,1,16'h0020,0, 1,16'h0102, 16'h0020,0,11,0);
    add(0,1,1,1,16'h0100,0, 0,16'h0021, 16'h0100,0,11,0); // branch during stall
    add(0,1,1,0,16'h0000,0, 0,16'h0101, 16'h0100,0,11,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0101, 16'h0101,1,12,0);
    add(0,1,0,1,16'hFFFF,0, 1,16'h0102, 16'hFFFF,0,13,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0000, 16'h0000,1,14,0); // wrap
    add(0,0,0,0,16'h0000,0, 1,16'h0001, 16'h0001,1,15,0); // RUN -> PAUSE
    add(0,0,0,0,16'h0000,0, 0,16'h0002, 16'h0001,1,15,0);
    add(0,0,0,1,16'h0200,0, 0,16'h0002, 16'h0200,0,15,0); // branch in PAUSE
    add(0,1,0,0,16'h0000,0, 0,16'h0201, 16'h0200,0,15,0); // PAUSE -> RUN
    add(0,1,0,0,16'h0000,0, 1,16'h0201, 16'h0201,1,16,0);
    add(0,0,0,1,16'h0300,0, 1,16'h0202, 16'h0300,0,17,0); // branch + enable falls
    add(0,0,0,0,16'h0000,0, 0,16'h0301, 16'h0300,0,17,0);
    add(0,1,0,0,16'h0000,0, 0,16'h0301, 16'h0300,0,17,0);
    add(0,1,0,1,16'h0400,1, 0,16'h0301, 16'h0300,0,17,1); // halt wins over branch
    add(0,0,0,0,16'h0000,0, 0,16'h0301, 16'h0300,0,17,1);
    add(0,1,0,0,16'h0000,0, 0,16'h0301, 16'h0300,0,17,1);
    add(0,1,0,1,16'h0500,0, 0,16'h0301, 16'h0300,0,17,1);
    add(1,0,0,0,16'h0000,0, 0,16'h0301, 16'h0000,0, 0,0); // rst out of HALT
    add(0,1,0,0,16'h0000,0, 0,16'h0001, 16'h0000,0, 0,0);
    add(0,1,0,1,16'h0042,0, 1,16'h0001, 16'h0042,0, 1,0);
    add(1,1,0,1,16'h0500,0, 1,16'h0043, 16'h0000,0, 0,0); // rst beats branch
    add(0,0,0,0,16'h0000,0, 0,16'h0001, 16'h0000,0, 0,0); // still IDLE
    add(0,0,0,0,16'h0000,1, 0,16'h0001, 16'h0000,0, 0,0); // halt ignored in IDLE
    add(0,1,0,0,16'h0000,0, 0,16'h0001, 16'h0000,0, 0,0);
    add(0,1,0,0,16'h0000,0, 1,16'h0001, 16'h0001,1, 1,0);

    // Reset held for two edges, then the reset state is checked directly.
    rst = 1'b1; enable_CPU = 1'b1; ena_n = 1'b0; branch_taken = 1'b0;
    branch_addr = 16'h1234; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; enable_CPU = 1'b0;
    #1;
    chk("reset rom_addr",    -1, 32'(rom_addr),    32'h0);
    chk("reset rom_en",      -1, 32'(rom_en),      32'h0);
    chk("reset fetch_valid", -1, 32'(fetch_valid), 32'h0);
    chk("reset fetch_count", -1, fetch_count,      32'h0);
    chk("reset halted",      -1, 32'(halted),      32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; enable_CPU = vecs[i].en; ena_n = vecs[i].ena_n;
      branch_taken = vecs[i].br; branch_addr = vecs[i].baddr; halt_req = vecs[i].halt;
      #1;
      chk("rom_en",      i, 32'(rom_en),      32'(vecs[i].x_en));
      chk("pc_next_inw", i, 32'(pc_next_inw), 32'(vecs[i].x_pcn));
      p.idx = i; p.addr = vecs[i].x_addr; p.fv = vecs[i].x_fv;
      p.cnt = vecs[i].x_cnt; p.hlt = vecs[i].x_halted;
      sb.push_back(p);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard empty vec=%0d actual=0 expected=1", i);
      end else begin
        p = sb.pop_front();
        chk("rom_addr",    p.idx, 32'(rom_addr),    32'(p.addr));
        chk("fetch_valid", p.idx, 32'(fetch_valid), 32'(p.fv));
        chk("fetch_count", p.idx, fetch_count,      p.cnt);
        chk("halted",      p.idx, 32'(halted),      32'(p.hlt));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
